// File: rtl/leader_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : leader_scheduler_pkg
// Brief  : State encodings and default sizing shared by the leader scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package leader_scheduler_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_SEARCH = 2'd2;
    localparam logic [1:0] c_ST_STALL  = 2'd3;

    localparam int c_DEF_N_NODES  = 4;
    localparam int c_DEF_SLOT_LEN = 8;
    localparam int c_DEF_T_WIDTH  = 5;

endpackage
`default_nettype wire

// File: rtl/leader_rr_next.sv
`default_nettype none
// ============================================================================
// Module : leader_rr_next
// Brief  : Combinational round-robin successor, (idx + 1) mod N_NODES.
// Rev    : 1.0  initial release
// ============================================================================
module leader_rr_next #(
    parameter  int N_NODES = 4,
    localparam int LW      = $clog2(N_NODES)
) (
    input  logic [LW-1:0] idx,
    output logic [LW-1:0] idx_next
);

    generate
        if ((1 << LW) == N_NODES) begin : g_pow2
            // Natural binary overflow already wraps at N_NODES
            assign idx_next = idx + LW'(1);
        end else begin : g_npow2
            localparam logic [LW-1:0] c_LAST = LW'(N_NODES - 1);
            assign idx_next = (idx == c_LAST) ? '0 : idx + LW'(1);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/leader_scheduler.sv
`default_nettype none
// ============================================================================
// Module : leader_scheduler
// Brief  : Round-robin leader rotation driven by a tick-advanced time counter.
//          Dead-node skipping is built when LEADER_SCHEDULER_SKIP_DEAD_EN is
//          defined; otherwise a pure rotation with alive ignored.
// Rev    : 1.0  initial release
// ============================================================================
module leader_scheduler
    import leader_scheduler_pkg::*;
#(
    parameter  int N_NODES  = c_DEF_N_NODES,
    parameter  int SLOT_LEN = c_DEF_SLOT_LEN,
    parameter  int T_WIDTH  = c_DEF_T_WIDTH,
    localparam int LW       = $clog2(N_NODES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               tick,
    input  logic [N_NODES-1:0] alive,
    output logic [LW-1:0]      leader,
    output logic               leader_valid,
    output logic               leader_change,
    output logic [T_WIDTH-1:0] t_out,
    output logic               wrapped,
    output logic               none_alive
);

    localparam int            SW          = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [SW-1:0] c_SLOT_LAST = SW'(SLOT_LEN - 1);

    logic [1:0]         r_state;
    logic [LW-1:0]      r_leader;
    logic [T_WIDTH-1:0] r_t;
    logic [SW-1:0]      r_slot;
    logic               r_change;
    logic               r_wrapped;

    logic [LW-1:0]      w_leader_next;
    logic               w_slot_end;

    leader_rr_next #(
        .N_NODES (N_NODES)
    ) u_rr_run (
        .idx      (r_leader),
        .idx_next (w_leader_next)
    );

    assign w_slot_end = tick && (r_slot == c_SLOT_LAST);

`ifdef LEADER_SCHEDULER_SKIP_DEAD_EN
    logic [LW-1:0] r_cand;
    logic [LW-1:0] r_miss;
    logic [LW-1:0] w_cand_next;
    localparam logic [LW-1:0] c_MISS_LAST = LW'(N_NODES - 1);

    leader_rr_next #(
        .N_NODES (N_NODES)
    ) u_rr_search (
        .idx      (r_cand),
        .idx_next (w_cand_next)
    );
`else
    logic w_unused_alive;
    assign w_unused_alive = ^alive;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_leader  <= '0;
            r_t       <= '0;
            r_slot    <= '0;
            r_change  <= 1'b0;
            r_wrapped <= 1'b0;
`ifdef LEADER_SCHEDULER_SKIP_DEAD_EN
            r_cand    <= '0;
            r_miss    <= '0;
`endif
        end else begin
            r_change  <= 1'b0;
            r_wrapped <= 1'b0;
            if (stop) begin
                // Leader and time freeze; any same-cycle tick is dropped
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            r_t      <= '0;
                            r_slot   <= '0;
                            r_leader <= '0;
                            r_change <= (r_leader != '0);
`ifdef LEADER_SCHEDULER_SKIP_DEAD_EN
                            r_cand   <= '0;
                            r_miss   <= '0;
                            r_state  <= c_ST_SEARCH;
`else
                            r_state  <= c_ST_RUN;
`endif
                        end
                    end

                    c_ST_RUN: begin
                        if (tick) begin
                            r_t       <= r_t + T_WIDTH'(1);
                            r_wrapped <= &r_t;
                            if (w_slot_end) begin
                                r_slot <= '0;
`ifdef LEADER_SCHEDULER_SKIP_DEAD_EN
                                r_cand  <= w_leader_next;
                                r_miss  <= '0;
                                r_state <= c_ST_SEARCH;
`else
                                r_leader <= w_leader_next;
                                r_change <= 1'b1;
`endif
                            end else begin
                                r_slot <= r_slot + SW'(1);
                            end
                        end
                    end

`ifdef LEADER_SCHEDULER_SKIP_DEAD_EN
                    c_ST_SEARCH: begin
                        if (tick) begin
                            r_t       <= r_t + T_WIDTH'(1);
                            r_wrapped <= &r_t;
                        end
                        if (alive[r_cand]) begin
                            r_leader <= r_cand;
                            r_change <= (r_cand != r_leader);
                            r_state  <= c_ST_RUN;
                        end else begin
                            // Candidate keeps advancing so a stall resumes
                            // where this search first started looking
                            r_cand <= w_cand_next;
                            if (r_miss == c_MISS_LAST) begin
                                r_state <= c_ST_STALL;
                            end else begin
                                r_miss <= r_miss + LW'(1);
                            end
                        end
                    end

                    c_ST_STALL: begin
                        if (tick) begin
                            r_t       <= r_t + T_WIDTH'(1);
                            r_wrapped <= &r_t;
                        end
                        if (|alive) begin
                            r_miss  <= '0;
                            r_state <= c_ST_SEARCH;
                        end
                    end
`endif

                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign leader        = r_leader;
    assign leader_valid  = (r_state == c_ST_RUN);
    assign leader_change = r_change;
    assign t_out         = r_t;
    assign wrapped       = r_wrapped;
`ifdef LEADER_SCHEDULER_SKIP_DEAD_EN
    assign none_alive    = (r_state == c_ST_STALL);
`else
    assign none_alive    = 1'b0;
`endif

endmodule
`default_nettype wire
